elastic_fifo_dataless: RTL and testbench



---
 rtl/elastic_fifo_dataless_if.sv | 22 ++
 rtl/elastic_fifo_dataless.sv | 57 +++++
 tb/tb_elastic_fifo_dataless.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/elastic_fifo_dataless_if.sv
// Dataless elastic handshake channel seen by the occupancy buffer.
// The master drives the token offer and the downstream accept; the slave answers with ready/valid.
interface elastic_fifo_dataless_if;
  logic ins_valid;
  logic ins_ready;
  logic outs_valid;
  logic outs_ready;

  modport master (
    output ins_valid,
    output outs_ready,
    input  ins_ready,
    input  outs_valid
  );

  modport slave (
    input  ins_valid,
    input  outs_ready,
    output ins_ready,
    output outs_valid
  );
endinterface

// File: rtl/elastic_fifo_dataless.sv
// Opaque multi-slot elastic buffer for dataless handshakes: holds up to NUM_SLOTS tokens as a count.
// ins_ready and outs_valid come straight from flops, so both valid/ready paths are cut.
module elastic_fifo_dataless #(
  parameter int NUM_SLOTS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  elastic_fifo_dataless_if.slave  bus
);

  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_SLOTS);

  if ((NUM_SLOTS < 1) || (NUM_SLOTS > 1024)) begin : g_bad_num_slots
    $error("elastic_fifo_dataless: NUM_SLOTS must lie in 1..1024");
  end

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          ins_ready_r;
  logic          outs_valid_r;
  logic          push_s;
  logic          pop_s;

  // Handshakes qualify on the registered flags only, never on a decode of count.
  assign push_s = bus.ins_valid & ins_ready_r;
  assign pop_s  = outs_valid_r & bus.outs_ready;

  // Occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Count and output flags share one edge; the flags look ahead at the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r      <= CNT_ZERO;
      outs_valid_r <= 1'b0;
      ins_ready_r  <= 1'b1;
    end else begin
      count_r      <= count_next_s;
      outs_valid_r <= (count_next_s != CNT_ZERO);
      ins_ready_r  <= (count_next_s != CNT_FULL);
    end
  end

  assign bus.ins_ready  = ins_ready_r;
  assign bus.outs_valid = outs_valid_r;

endmodule

// File: tb/tb_elastic_fifo_dataless.sv
// Self-checking bench: three buffer instances (4, 1 and 3 slots) against an occupancy-count model.
module tb_elastic_fifo_dataless;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  elastic_fifo_dataless_if b4 ();
  elastic_fifo_dataless_if b1 ();
  elastic_fifo_dataless_if b3 ();

  elastic_fifo_dataless #(.NUM_SLOTS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  elastic_fifo_dataless #(.NUM_SLOTS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  elastic_fifo_dataless #(.NUM_SLOTS(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  // Reference model: token count per instance, index 0 -> 4 slots, 1 -> 1 slot, 2 -> 3 slots.
  int mc [3];
  int ns [3] = '{4, 1, 3};
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic set_in(input int k, input logic iv, input logic orr);
    case (k)
      0:       begin b4.ins_valid = iv; b4.outs_ready = orr; end
      1:       begin b1.ins_valid = iv; b1.outs_ready = orr; end
      default: begin b3.ins_valid = iv; b3.outs_ready = orr; end
    endcase
  endtask

  task automatic get_out(input int k, output logic ir, output logic ov);
    case (k)
      0:       begin ir = b4.ins_ready; ov = b4.outs_valid; end
      1:       begin ir = b1.ins_ready; ov = b1.outs_valid; end
      default: begin ir = b3.ins_ready; ov = b3.outs_valid; end
    endcase
  endtask

  task automatic get_count(input int k, output int c);
    case (k)
      0:       c = int'(dut4.count_r);
      1:       c = int'(dut1.count_r);
      default: c = int'(dut3.count_r);
    endcase
  endtask

  // One clock cycle on instance k; starts and ends 1 time unit after a rising edge.
  task automatic step(input int k, input logic iv, input logic orr, input bit toggle,
                      output logic ir_seen, output logic ov_seen);
    logic ir, ov, ir2, ov2, exp_ir, exp_ov;
    int c, push, pop;
    set_in(k, iv, orr);
    #1;
    get_out(k, ir, ov);
    ir_seen = ir;
    ov_seen = ov;
    exp_ir = (mc[k] < ns[k]);
    exp_ov = (mc[k] > 0);
    total_cnt++;
    if (ir !== exp_ir || ov !== exp_ov)
      $display("FAIL outputs k=%0d ready=%b/%b valid=%b/%b (got/want)", k, ir, exp_ir, ov, exp_ov);
    else
      pass_cnt++;
    if (toggle) begin
      set_in(k, ~iv, ~orr);
      #1;
      get_out(k, ir2, ov2);
      total_cnt++;
      if (ir2 !== exp_ir || ov2 !== exp_ov)
        $display("FAIL comb_path k=%0d ready=%b/%b valid=%b/%b (got/want)", k, ir2, exp_ir, ov2, exp_ov);
      else
        pass_cnt++;
      set_in(k, iv, orr);
    end
    push = (iv && mc[k] < ns[k]) ? 1 : 0;
    pop  = (orr && mc[k] > 0) ? 1 : 0;
    @(posedge clk);
    #1;
    mc[k] = mc[k] + push - pop;
    get_count(k, c);
    total_cnt++;
    if (c !== mc[k] || c > ns[k])
      $display("FAIL count k=%0d got=%0d want=%0d max=%0d", k, c, mc[k], ns[k]);
    else
      pass_cnt++;
  endtask

  task automatic check_idle_reset(input string name);
    logic ir, ov;
    int c;
    for (int k = 0; k < 3; k++) begin
      get_out(k, ir, ov);
      get_count(k, c);
      total_cnt++;
      if (ir !== 1'b1 || ov !== 1'b0 || c !== 0)
        $display("FAIL %s k=%0d ready=%b valid=%b count=%0d want 1 0 0", name, k, ir, ov, c);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) set_in(k, 1'b0, 1'b0);
    #1;
    check_idle_reset("reset_state");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) mc[k] = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop();
    logic ir, ov;
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 1'b0, ir, ov);
    set_in(0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_reset("reset_midop");
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) mc[k] = 0;
    set_in(0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    logic ir, ov;
    int pushes = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1'b1, 1'b0, 1'b0, ir, ov);
      if (ir === 1'b1) pushes++;
      total_cnt++;
      if (ir !== ((i < 4) ? 1'b1 : 1'b0) || ov !== ((i >= 1) ? 1'b1 : 1'b0))
        $display("FAIL fill_cycle%0d ready=%b valid=%b", i + 1, ir, ov);
      else
        pass_cnt++;
    end
    total_cnt++;
    if (pushes !== 4) $display("FAIL fill_pushes got=%0d want=4", pushes);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    logic ir, ov, ir_after_first;
    int pops = 0;
    ir_after_first = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b0, 1'b1, 1'b0, ir, ov);
      if (ov === 1'b1) pops++;
      if (i == 1) ir_after_first = ir;
    end
    total_cnt++;
    if (pops !== 4 || ir_after_first !== 1'b1 || ov !== 1'b0)
      $display("FAIL drain pops=%0d want 4 ready_after_first=%b last_valid=%b", pops, ir_after_first, ov);
    else
      pass_cnt++;
  endtask

  task automatic test_full_pop();
    logic ir, ov;
    int c;
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1'b0, ir, ov);
    step(0, 1'b1, 1'b1, 1'b0, ir, ov);
    get_count(0, c);
    total_cnt++;
    if (ir !== 1'b0 || ov !== 1'b1 || c !== 3)
      $display("FAIL full_pop ready=%b valid=%b count=%0d want 0 1 3", ir, ov, c);
    else
      pass_cnt++;
    step(0, 1'b1, 1'b1, 1'b0, ir, ov);
    get_count(0, c);
    total_cnt++;
    if (ir !== 1'b1 || ov !== 1'b1 || c !== 3)
      $display("FAIL push_and_pop ready=%b valid=%b count=%0d want 1 1 3", ir, ov, c);
    else
      pass_cnt++;
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 1'b0, ir, ov);
  endtask

  task automatic test_stream_single();
    logic ir, ov;
    int tokens = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1'b1, 1'b1, 1'b0, ir, ov);
      if (ov === 1'b1) tokens++;
      total_cnt++;
      if (ov !== logic'(i % 2) || ir !== ~ov)
        $display("FAIL single_slot_cycle%0d valid=%b ready=%b want valid=%0d", i, ov, ir, i % 2);
      else
        pass_cnt++;
    end
    total_cnt++;
    if (tokens !== 5) $display("FAIL single_slot_tokens got=%0d want=5", tokens);
    else pass_cnt++;
    set_in(1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic ir, ov, iv, orr;
    int pushes = 0, pops = 0, c;
    iv = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      // Upstream keeps an offered token until it is accepted.
      if (!iv) iv = logic'($urandom_range(1, 0));
      orr = logic'($urandom_range(1, 0));
      step(2, iv, orr, (i % 4) == 0, ir, ov);
      if (iv && ir) begin pushes++; iv = 1'b0; end
      if (orr && ov) pops++;
    end
    set_in(2, 1'b0, 1'b0);
    get_count(2, c);
    total_cnt++;
    if (pops !== pushes - c)
      $display("FAIL random_balance pops=%0d want=%0d (pushes=%0d count=%0d)", pops, pushes - c, pushes, c);
    else
      pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_pop();
    test_reset_midop();
    test_stream_single();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
